mpi_chan_arbiter: RTL and testbench
===================================

Name: mpi_chan_arbiter

Overview:
Shares one MPI transport port between NUM_CH local val/yummy NoC channels, such as P-Mesh NoC1..3, in an MPI-bridged fake node.
- Local side: acts as the val/yummy receiver for each channel. Buffers flits in a small per-channel FIFO and returns a yummy when a flit leaves for MPI.
- Remote side: keeps a per-channel credit counter for the remote buffer. Only schedules flits that have credit.
- Selects among eligible channels round-robin and drives a valid/ready transport interface toward the DPI/MPI layer.

Parameters:
NUM_CH, 3, number of local channels sharing the MPI port
DATA_W, 64, flit width
DEPTH, 4, per-channel local FIFO depth (power of 2)
CREDITS, 8, initial/max remote credits per channel

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset; one clock, reset asynchronous, active-low
ch_valid_i  in  NUM_CH  local flit valid, one bit per channel
ch_data_i  in  NUM_CH*DATA_W  local flit data; channel c occupies bits [c*DATA_W +: DATA_W]
ch_yummy_o  out  NUM_CH  one-cycle credit return to local sender c
tx_valid_o  out  1  flit offered to MPI transport
tx_ch_o  out  $clog2(NUM_CH)  channel id of offered flit
tx_data_o  out  DATA_W  offered flit
tx_ready_i  in  1  transport accepts; handshake = tx_valid_o & tx_ready_i
rem_yummy_i  in  NUM_CH  remote credit return pulses (from mpi_receive_yummy)
err_o  out  2  sticky: [0] local FIFO overflow, [1] remote credit overflow

Behaviour:
- Reset (async assert) clears state immediately:
  - all FIFOs empty; credit[c]=CREDITS
  - rr_ptr=NUM_CH-1, so channel 0 has first priority
  - FSM=IDLE
  - tx_valid_o=0, tx_ch_o=0, tx_data_o=0, ch_yummy_o=0, err_o=0
- FIFO push: on each edge, for every c with ch_valid_i[c], write ch_data_i slice.
  - If FIFO full and not popping in the same cycle: drop the flit and set err_o[0].
  - Push and pop in the same cycle are both honoured, including when full; count is unchanged.
- Eligibility: elig[c] = FIFO c non-empty & credit[c]!=0.
- FSM IDLE: if any elig, grant the first eligible channel searching rr_ptr+1, rr_ptr+2, … with modulo-NUM_CH wrap.
  - Register tx_ch_o=grant and tx_data_o=FIFO head.
  - Set tx_valid_o=1 and go to SEND.
  - Otherwise stay in IDLE with tx_valid_o=0.
- FSM SEND: hold tx_valid_o/tx_ch_o/tx_data_o stable while tx_ready_i=0. No timeout.
  - On handshake: pop FIFO[grant], credit[grant]-=1, rr_ptr=grant, tx_valid_o=0, go to IDLE.
  - ch_yummy_o[grant] is registered and asserted for exactly the one cycle following the handshake edge.
- Throughput: max one flit per 2 cycles. Latency from push edge E0: tx_valid_o high after E1 (FIFO previously empty, credit available, FSM in IDLE).
- Credits: credit[c] is $clog2(CREDITS+1) bits.
  - rem_yummy_i[c] increments credit[c].
  - Handshake decrement and rem_yummy_i on the same channel in the same cycle: net unchanged.
  - rem_yummy_i at credit==CREDITS with no simultaneous decrement: saturate and set err_o[1].
  - credit never underflows; grant requires credit!=0.
- Credit changes take effect for the next IDLE decision; no re-check while in SEND.
- err_o bits clear only on reset.

Test Plan:
1. Reset release, then single push on ch1 data 64'hDEAD_BEEF_0000_0001 at E0, tx_ready_i=1.
   -> tx_valid_o=1, tx_ch_o=1, tx_data_o=64'hDEAD_BEEF_0000_0001 after E1; handshake at E2; ch_yummy_o=3'b010 for one cycle after E2; credit[1]=7; err_o=0.
2. Same-cycle push on ch0, ch1, ch2 (data 'h10, 'h11, 'h12), tx_ready_i=1.
   -> transmit order ch0, ch1, ch2 on consecutive handshakes 2 cycles apart.
   -> repeating the stimulus gives order 0, 1, 2 again (rr_ptr=2).
3. Bench sender obeying DEPTH=4 local credits streams 10 flits on ch0, no rem_yummy_i.
   -> exactly 8 handshakes, then tx_valid_o stays 0.
   -> one rem_yummy_i[0] pulse -> 9th flit sent within 2 cycles.
4. Flit pending, tx_ready_i=0 for 5 cycles.
   -> tx_valid_o/tx_ch_o/tx_data_o stable; no ch_yummy_o; credit unchanged.
   -> tx_ready_i=1 -> single handshake.
5. tx_ready_i=0, 5 pushes on ch2 -> err_o[0]=1, 5th flit dropped, later only 4 transmitted.
   rem_yummy_i[1] at credit 8 -> err_o[1]=1, credit[1] stays 8.
6. Assert rstn_i low mid-SEND -> tx_valid_o=0 without waiting for an edge.
   -> after release: no transmit, FIFOs empty, all credits 8, err_o=0.

Source files
------------

// File: rtl/mpi_chan_arbiter.sv
// mpi_chan_arbiter: several local val/yummy NoC channels share one MPI
// transport port. Each channel has a small local FIFO and a counter of the
// credits left in the remote buffer. Round-robin selection feeds a
// valid/ready transport interface.
module mpi_chan_arbiter #(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 4,
  parameter int CREDITS = 8
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [NUM_CH-1:0]          ch_valid_i,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data_i,
  output logic [NUM_CH-1:0]          ch_yummy_o,
  output logic                       tx_valid_o,
  output logic [$clog2(NUM_CH)-1:0]  tx_ch_o,
  output logic [DATA_W-1:0]          tx_data_o,
  input  logic                       tx_ready_i,
  input  logic [NUM_CH-1:0]          rem_yummy_i,
  output logic [1:0]                 err_o
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int AW   = $clog2(DEPTH);
  localparam int CR_W = $clog2(CREDITS + 1);
  localparam logic [CR_W-1:0] CR_MAX = CR_W'(CREDITS);
  localparam logic [AW:0]     FULL   = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state;
  logic [CH_W-1:0]     rr_ptr;
  logic [DATA_W-1:0]   fifo_mem [NUM_CH][DEPTH];
  logic [AW-1:0]       wr_ptr   [NUM_CH];
  logic [AW-1:0]       rd_ptr   [NUM_CH];
  logic [AW:0]         count    [NUM_CH];
  logic [CR_W-1:0]     credit   [NUM_CH];
  logic                err_fifo;
  logic                err_cred;

  logic                handshake;
  logic [NUM_CH-1:0]   pop_vec;
  logic [NUM_CH-1:0]   push_ok;
  logic [NUM_CH-1:0]   elig;
  logic                any_elig;
  logic [CH_W-1:0]     grant_sel;
  logic [CH_W-1:0]     cand;
  logic [DATA_W-1:0]   grant_head;

  assign handshake = tx_valid_o & tx_ready_i;
  assign err_o     = {err_cred, err_fifo};

  // Per-channel push/pop qualifiers and eligibility; a full FIFO still accepts a push when it pops in the same cycle
  always_comb begin
    pop_vec = '0;
    push_ok = '0;
    elig    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pop_vec[c] = handshake && (tx_ch_o == CH_W'(c));
      push_ok[c] = ch_valid_i[c] && ((count[c] != FULL) || pop_vec[c]);
      elig[c]    = (count[c] != '0) && (credit[c] != '0);
    end
  end

  // Round-robin search starting just after the last granted channel
  always_comb begin
    any_elig  = 1'b0;
    grant_sel = '0;
    cand      = rr_ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = (cand == CH_W'(NUM_CH - 1)) ? '0 : cand + CH_W'(1);
      if (!any_elig && elig[cand]) begin
        any_elig  = 1'b1;
        grant_sel = cand;
      end
    end
    grant_head = fifo_mem[grant_sel][rd_ptr[grant_sel]];
  end

  // FIFO storage; the contents need no reset because the pointers qualify them
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_ok[c]) fifo_mem[c][wr_ptr[c]] <= ch_data_i[c*DATA_W +: DATA_W];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
      err_fifo <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push_ok[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
        if (pop_vec[c]) rd_ptr[c] <= rd_ptr[c] + AW'(1);
        if (ch_valid_i[c] && !push_ok[c]) err_fifo <= 1'b1;
        if (push_ok[c] && !pop_vec[c])      count[c] <= count[c] + (AW + 1)'(1);
        else if (!push_ok[c] && pop_vec[c]) count[c] <= count[c] - (AW + 1)'(1);
      end
    end
  end

  // Remote credit counters: consumed on handshake, returned by remote yummies, saturating at the maximum
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < NUM_CH; c++) credit[c] <= CR_MAX;
      err_cred <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (rem_yummy_i[c] && !pop_vec[c]) begin
          if (credit[c] == CR_MAX) err_cred <= 1'b1;
          else                     credit[c] <= credit[c] + CR_W'(1);
        end else if (!rem_yummy_i[c] && pop_vec[c]) begin
          credit[c] <= credit[c] - CR_W'(1);
        end
      end
    end
  end

  // Scheduler FSM with registered transport outputs and local yummy pulses
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      rr_ptr     <= CH_W'(NUM_CH - 1);
      tx_valid_o <= 1'b0;
      tx_ch_o    <= '0;
      tx_data_o  <= '0;
      ch_yummy_o <= '0;
    end else begin
      ch_yummy_o <= pop_vec;
      case (state)
        IDLE: begin
          if (any_elig) begin
            tx_ch_o    <= grant_sel;
            tx_data_o  <= grant_head;
            tx_valid_o <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (tx_ready_i) begin
            rr_ptr     <= tx_ch_o;
            tx_valid_o <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpi_chan_arbiter.sv
// Directed testbench for mpi_chan_arbiter: reset, latency, round-robin,
// remote credit exhaustion, back-pressure, overflow flags and async reset.
module tb_mpi_chan_arbiter;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic [2:0]    ch_valid_i = '0;
  logic [191:0]  ch_data_i = '0;
  logic [2:0]    ch_yummy_o;
  logic          tx_valid_o;
  logic [1:0]    tx_ch_o;
  logic [63:0]   tx_data_o;
  logic          tx_ready_i = 1'b0;
  logic [2:0]    rem_yummy_i = '0;
  logic [1:0]    err_o;

  int checks = 0;
  int errors = 0;

  mpi_chan_arbiter #(.NUM_CH(3), .DATA_W(64), .DEPTH(4), .CREDITS(8)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .ch_valid_i  (ch_valid_i),
    .ch_data_i   (ch_data_i),
    .ch_yummy_o  (ch_yummy_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ch_o     (tx_ch_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .rem_yummy_i (rem_yummy_i),
    .err_o       (err_o)
  );

  // 10 ns clock
  always #5 clk_i = ~clk_i;

  // Advance one rising edge and settle 1 ns past it
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] valid, input logic [63:0] d0,
                               input logic [63:0] d1, input logic [63:0] d2,
                               input logic ready, input logic [2:0] remy);
    ch_valid_i         = valid;
    ch_data_i[63:0]    = d0;
    ch_data_i[127:64]  = d1;
    ch_data_i[191:128] = d2;
    tx_ready_i         = ready;
    rem_yummy_i        = remy;
  endtask

  task automatic doReset();
    rstn_i = 1'b0;
    applyStimulus(3'b000, 64'h0, 64'h0, 64'h0, 1'b0, 3'b000);
    step();
    step();
    rstn_i = 1'b1;
  endtask

  initial begin
    int lcred;
    int sent;
    int hs;

    // ---------------- Reset state ----------------
    doReset();
    checkOutput("rst_valid", 64'(tx_valid_o), 64'h0);
    checkOutput("rst_ch",    64'(tx_ch_o),    64'h0);
    checkOutput("rst_data",  tx_data_o,       64'h0);
    checkOutput("rst_yummy", 64'(ch_yummy_o), 64'h0);
    checkOutput("rst_err",   64'(err_o),      64'h0);

    // ---------------- 1: single push on ch1 ----------------
    applyStimulus(3'b010, 64'h0, 64'hDEAD_BEEF_0000_0001, 64'h0, 1'b1, 3'b000);
    step();  // E0
    applyStimulus(3'b000, 64'h0, 64'h0, 64'h0, 1'b1, 3'b000);
    checkOutput("t1_valid_e0", 64'(tx_valid_o), 64'h0);
    step();  // E1
    checkOutput("t1_valid_e1", 64'(tx_valid_o), 64'h1);
    checkOutput("t1_ch_e1",    64'(tx_ch_o),    64'h1);
    checkOutput("t1_data_e1",  tx_data_o,       64'hDEAD_BEEF_0000_0001);
    step();  // E2 handshake
    checkOutput("t1_valid_e2", 64'(tx_valid_o), 64'h0);
    checkOutput("t1_yummy_e2", 64'(ch_yummy_o), 64'h2);
    checkOutput("t1_credit1",  64'(dut.credit[1]), 64'h7);
    checkOutput("t1_err",      64'(err_o),      64'h0);
    step();
    checkOutput("t1_yummy_e3", 64'(ch_yummy_o), 64'h0);

    // ---------------- 2: round-robin from reset, twice ----------------
    doReset();
    for (int rep = 0; rep < 2; rep++) begin
      applyStimulus(3'b111, 64'h10, 64'h11, 64'h12, 1'b1, 3'b000);
      step();
      applyStimulus(3'b000, 64'h0, 64'h0, 64'h0, 1'b1, 3'b000);
      for (int k = 0; k < 3; k++) begin
        step();
        checkOutput($sformatf("t2_r%0d_valid%0d", rep, k), 64'(tx_valid_o), 64'h1);
        checkOutput($sformatf("t2_r%0d_ch%0d", rep, k),    64'(tx_ch_o),    64'(k));
        checkOutput($sformatf("t2_r%0d_data%0d", rep, k),  tx_data_o,       64'(16 + k));
        step();
        checkOutput($sformatf("t2_r%0d_yummy%0d", rep, k), 64'(ch_yummy_o), 64'(1 << k));
      end
      step();
      checkOutput($sformatf("t2_r%0d_idle", rep), 64'(tx_valid_o), 64'h0);
    end

    // ---------------- 3: remote credit exhaustion on ch0 ----------------
    doReset();
    tx_ready_i = 1'b1;
    lcred = 4;
    sent  = 0;
    hs    = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (sent < 10 && lcred > 0) begin
        ch_valid_i      = 3'b001;
        ch_data_i[63:0] = 64'(256 + sent);
        lcred--;
        sent++;
      end else begin
        ch_valid_i = 3'b000;
      end
      if (tx_valid_o && tx_ready_i) begin
        checkOutput($sformatf("t3_data%0d", hs), tx_data_o, 64'(256 + hs));
        hs++;
      end
      step();
      if (ch_yummy_o[0]) lcred++;
    end
    ch_valid_i = 3'b000;
    checkOutput("t3_sent",       64'(sent),        64'd10);
    checkOutput("t3_handshakes", 64'(hs),          64'd8);
    checkOutput("t3_stall",      64'(tx_valid_o),  64'h0);
    rem_yummy_i = 3'b001;
    step();
    rem_yummy_i = 3'b000;
    checkOutput("t3_after_rem0", 64'(tx_valid_o), 64'h0);
    step();
    checkOutput("t3_resume_valid", 64'(tx_valid_o), 64'h1);
    checkOutput("t3_resume_data",  tx_data_o,       64'h108);
    step();
    checkOutput("t3_resume_yummy", 64'(ch_yummy_o), 64'h1);

    // ---------------- 4: back-pressure hold ----------------
    doReset();
    applyStimulus(3'b100, 64'h0, 64'h0, 64'hABC, 1'b0, 3'b000);
    step();
    applyStimulus(3'b000, 64'h0, 64'h0, 64'h0, 1'b0, 3'b000);
    step();
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("t4_valid%0d", k),  64'(tx_valid_o), 64'h1);
      checkOutput($sformatf("t4_ch%0d", k),     64'(tx_ch_o),    64'h2);
      checkOutput($sformatf("t4_data%0d", k),   tx_data_o,       64'hABC);
      checkOutput($sformatf("t4_yummy%0d", k),  64'(ch_yummy_o), 64'h0);
      checkOutput($sformatf("t4_credit%0d", k), 64'(dut.credit[2]), 64'h8);
      step();
    end
    tx_ready_i = 1'b1;
    step();
    checkOutput("t4_hs_valid",  64'(tx_valid_o), 64'h0);
    checkOutput("t4_hs_yummy",  64'(ch_yummy_o), 64'h4);
    checkOutput("t4_hs_credit", 64'(dut.credit[2]), 64'h7);
    step();
    checkOutput("t4_single_valid", 64'(tx_valid_o), 64'h0);
    checkOutput("t4_single_yummy", 64'(ch_yummy_o), 64'h0);

    // ---------------- 5: overflow flags ----------------
    doReset();
    tx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ch_valid_i         = 3'b100;
      ch_data_i[191:128] = 64'(512 + i);
      step();
      checkOutput($sformatf("t5_err_push%0d", i), 64'(err_o), (i == 4) ? 64'h1 : 64'h0);
    end
    ch_valid_i = 3'b000;
    tx_ready_i = 1'b1;
    hs = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (tx_valid_o && tx_ready_i) begin
        checkOutput($sformatf("t5_data%0d", hs), tx_data_o, 64'(512 + hs));
        hs++;
      end
      step();
    end
    checkOutput("t5_handshakes", 64'(hs), 64'd4);
    rem_yummy_i = 3'b010;
    step();
    rem_yummy_i = 3'b000;
    checkOutput("t5_err_both", 64'(err_o), 64'h3);
    checkOutput("t5_credit1",  64'(dut.credit[1]), 64'h8);

    // ---------------- 6: async reset mid-SEND ----------------
    doReset();
    applyStimulus(3'b001, 64'h77, 64'h0, 64'h0, 1'b0, 3'b000);
    step();
    applyStimulus(3'b000, 64'h0, 64'h0, 64'h0, 1'b0, 3'b000);
    step();
    checkOutput("t6_pre_valid", 64'(tx_valid_o), 64'h1);
    #2;
    rstn_i = 1'b0;
    #1;
    checkOutput("t6_async_valid", 64'(tx_valid_o), 64'h0);
    checkOutput("t6_async_data",  tx_data_o,       64'h0);
    step();
    rstn_i = 1'b1;
    tx_ready_i = 1'b1;
    hs = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (tx_valid_o) hs++;
      step();
    end
    checkOutput("t6_no_tx", 64'(hs), 64'd0);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("t6_count%0d", c),  64'(dut.count[c]),  64'h0);
      checkOutput($sformatf("t6_credit%0d", c), 64'(dut.credit[c]), 64'h8);
    end
    checkOutput("t6_err", 64'(err_o), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
